// File: rtl/sw_debouncer.sv
// Multi-channel switch debouncer: synchroniser chain + per-channel stability FSM.
// Optional DEBOUNCE_BUSY_EN adds o_busy, high while a channel is settling.
module sw_debouncer #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 20
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_sw,
    output logic [N_CH-1:0] o_sw
`ifdef DEBOUNCE_BUSY_EN
    ,
    output logic [N_CH-1:0] o_busy
`endif
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    logic [N_CH-1:0]  r_sync [SYNC_STAGES];
    logic [N_CH-1:0]  w_s;
    state_t           r_state [N_CH];
    state_t           w_state_nx [N_CH];
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [CNT_W-1:0] w_cnt_nx [N_CH];
    logic [N_CH-1:0]  r_sw;
    logic [N_CH-1:0]  w_sw_nx;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Any opposite-level sample while waiting drops back to the old stable state.
    always_comb begin
        w_sw_nx = r_sw;
        for (int k = 0; k < N_CH; k++) begin
            w_state_nx[k] = r_state[k];
            w_cnt_nx[k]   = r_cnt[k];
            unique case (r_state[k])
                STABLE_LO: begin
                    if (w_s[k]) begin
                        w_state_nx[k] = WAIT_HI;
                        w_cnt_nx[k]   = CNT_W'(1);
                    end else begin
                        w_cnt_nx[k] = '0;
                    end
                end
                WAIT_HI: begin
                    if (!w_s[k]) begin
                        w_state_nx[k] = STABLE_LO;
                        w_cnt_nx[k]   = '0;
                    end else if (r_cnt[k] == CNT_W'(DB_CYCLES)) begin
                        w_state_nx[k] = STABLE_HI;
                        w_sw_nx[k]    = 1'b1;
                        w_cnt_nx[k]   = '0;
                    end else begin
                        w_cnt_nx[k] = r_cnt[k] + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!w_s[k]) begin
                        w_state_nx[k] = WAIT_LO;
                        w_cnt_nx[k]   = CNT_W'(1);
                    end else begin
                        w_cnt_nx[k] = '0;
                    end
                end
                WAIT_LO: begin
                    if (w_s[k]) begin
                        w_state_nx[k] = STABLE_HI;
                        w_cnt_nx[k]   = '0;
                    end else if (r_cnt[k] == CNT_W'(DB_CYCLES)) begin
                        w_state_nx[k] = STABLE_LO;
                        w_sw_nx[k]    = 1'b0;
                        w_cnt_nx[k]   = '0;
                    end else begin
                        w_cnt_nx[k] = r_cnt[k] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sw <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_state[k] <= STABLE_LO;
                r_cnt[k]   <= '0;
            end
        end else begin
            r_sw <= w_sw_nx;
            for (int k = 0; k < N_CH; k++) begin
                r_state[k] <= w_state_nx[k];
                r_cnt[k]   <= w_cnt_nx[k];
            end
        end
    end

    assign o_sw = r_sw;

`ifdef DEBOUNCE_BUSY_EN
    logic [N_CH-1:0] r_busy;
    logic [N_CH-1:0] w_busy_nx;

    always_comb begin
        w_busy_nx = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_busy_nx[k] = (w_state_nx[k] == WAIT_HI)
                        || (w_state_nx[k] == WAIT_LO);
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nx;
        end
    end

    assign o_busy = r_busy;
`endif

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer (2 channels, 2 sync stages, DB_CYCLES=4).
// Expected o_sw per clock edge is queued up front and popped after each edge.
module tb_sw_debouncer;

    logic       clk;
    logic       i_rst;
    logic [1:0] i_sw;
    logic [1:0] o_sw;
    logic [1:0] o_busy;

    typedef struct {
        logic [1:0] sw;
        logic [1:0] busy;
        bit         bchk;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;

    sw_debouncer #(
        .N_CH(2),
        .SYNC_STAGES(2),
        .DB_CYCLES(4)
    ) dut (
        .clk(clk),
        .i_rst(i_rst),
        .i_sw(i_sw),
        .o_sw(o_sw)
`ifdef DEBOUNCE_BUSY_EN
        ,
        .o_busy(o_busy)
`endif
    );

`ifndef DEBOUNCE_BUSY_EN
    assign o_busy = 2'b00;
`endif

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic push(input logic [1:0] sw, input int n, input string tag,
                        input bit bchk = 1'b0, input logic [1:0] busy = 2'b00);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sw   = sw;
            e.busy = busy;
            e.bchk = bchk;
            e.tag  = tag;
            q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $error("FAIL sb_underflow o_sw=%b required=queued entry", o_sw);
            end else begin
                e = q.pop_front();
                assert (o_sw === e.sw) else begin
                    failures++;
                    $error("FAIL %s o_sw got=%b exp=%b", e.tag, o_sw, e.sw);
                end
`ifdef DEBOUNCE_BUSY_EN
                if (e.bchk) begin
                    checks++;
                    assert (o_busy === e.busy) else begin
                        failures++;
                        $error("FAIL %s_busy o_busy got=%b exp=%b",
                               e.tag, o_busy, e.busy);
                    end
                end
`endif
            end
        end
    endtask

    task automatic chk_now(input string tag, input logic [1:0] sw);
        checks++;
        assert (o_sw === sw) else begin
            failures++;
            $error("FAIL %s o_sw got=%b exp=%b", tag, o_sw, sw);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        i_sw     = 2'b11;
        i_rst    = 1'b1;
        #1 i_rst = 1'b0;
        #3 chk_now("rst_async", 2'b00);

        // Reset held ~50 ns with both switches high
        push(2'b00, 3, "rst_hold");
        step(3);
        i_rst = 1'b1;
        push(2'b00, 6, "rst_lat");
        push(2'b11, 3, "rst_rise");
        step(9);

        // Release both
        i_sw = 2'b00;
        push(2'b11, 6, "rel_lat");
        push(2'b00, 2, "rel_fall");
        step(8);

        // Clean press and release on ch0
        i_sw = 2'b01;
        push(2'b00, 6, "press_lat");
        push(2'b01, 2, "press_rise");
        step(8);
        i_sw = 2'b00;
        push(2'b01, 6, "rls_lat");
        push(2'b00, 2, "rls_fall");
        step(8);

        // Bounce on ch0: 2 clocks per level, then settle high
        for (int b = 0; b < 2; b++) begin
            i_sw = 2'b01;
            push(2'b00, 2, "bounce_hi");
            step(2);
            i_sw = 2'b00;
            push(2'b00, 2, "bounce_lo");
            step(2);
        end
        i_sw = 2'b01;
        push(2'b00, 6, "bounce_lat");
        push(2'b01, 2, "bounce_rise");
        step(8);
        i_sw = 2'b00;
        push(2'b01, 6, "bounce_rls");
        push(2'b00, 3, "bounce_fall");
        step(9);

        // Short glitch on ch1: exactly DB_CYCLES clocks high
        i_sw = 2'b10;
        push(2'b00, 2, "glitch", 1'b1, 2'b00);
        push(2'b00, 2, "glitch", 1'b1, 2'b10);
        step(4);
        i_sw = 2'b00;
        push(2'b00, 2, "glitch", 1'b1, 2'b10);
        push(2'b00, 6, "glitch_end", 1'b1, 2'b00);
        step(8);

        // Reset mid-count on ch0
        i_sw = 2'b01;
        push(2'b00, 3, "midrst_pre");
        step(3);
        #4 i_rst = 1'b0;
        #1 chk_now("midrst_async", 2'b00);
`ifdef DEBOUNCE_BUSY_EN
        checks++;
        assert (o_busy === 2'b00) else begin
            failures++;
            $error("FAIL midrst_busy o_busy got=%b exp=%b", o_busy, 2'b00);
        end
`endif
        push(2'b00, 1, "midrst_hold");
        step(1);
        i_rst = 1'b1;
        push(2'b00, 6, "midrst_lat");
        push(2'b01, 2, "midrst_rise");
        step(8);
        i_sw = 2'b00;
        push(2'b01, 6, "midrst_rls");
        push(2'b00, 2, "midrst_fall");
        step(8);

        // Channel independence: ch1 follows ch0 by two clocks
        i_sw = 2'b01;
        push(2'b00, 2, "indep_a");
        step(2);
        i_sw = 2'b11;
        push(2'b00, 4, "indep_b");
        push(2'b01, 2, "indep_ch0");
        push(2'b11, 3, "indep_both");
        step(9);

        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover size got=%0d exp=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
